// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encodings, funct codes and sizing for the divider
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_BUSY    = 2'd2,
    S_DONE    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage to divider request/result bundle
interface div_unit_if;
  import div_unit_pkg::*;

  logic                     start;
  logic                     signed_div;
  logic                     annul;
  logic [DIV_WIDTH-1:0]     opdata1;
  logic [DIV_WIDTH-1:0]     opdata2;
  logic [2*DIV_WIDTH-1:0]   result;
  logic                     ready;
  logic                     stall;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result, ready, stall
  );

endinterface

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring radix-2 compare/subtract/shift step
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic [DIV_WIDTH-1:0] i_quo,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic [DIV_WIDTH-1:0] o_quo
);

  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH+2:0] w_diff;

  // Extra guard bits so the borrow out of the trial subtract is always visible.
  assign w_shift = {i_rem, i_quo[DIV_WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {3'b000, i_divisor};

  assign o_rem = w_diff[DIV_WIDTH+2] ? w_shift[DIV_WIDTH:0] : w_diff[DIV_WIDTH:0];
  assign o_quo = {i_quo[DIV_WIDTH-2:0], ~w_diff[DIV_WIDTH+2]};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned 32-bit divider for HI/LO
// Optional DIV_ZERO_FAST_EN: zero divisor short-circuits through DIVZERO.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_ITERS - 1);

  div_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [DIV_WIDTH:0]     r_rem;
  logic [DIV_WIDTH-1:0]   r_quo;
  logic [DIV_WIDTH-1:0]   r_divisor;
  logic [DIV_WIDTH-1:0]   r_dividend;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_dz;
  logic [2*DIV_WIDTH-1:0] r_result;
  logic                   r_ready;

  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [DIV_WIDTH-1:0]   w_a_mag;
  logic [DIV_WIDTH-1:0]   w_b_mag;
  logic                   w_b_zero;
  logic [DIV_WIDTH:0]     w_rem;
  logic [DIV_WIDTH-1:0]   w_quo;
  logic [DIV_WIDTH-1:0]   w_q_fix;
  logic [DIV_WIDTH-1:0]   w_r_fix;
  logic [2*DIV_WIDTH-1:0] w_dz_result;

  assign w_a_neg     = bus.signed_div & bus.opdata1[DIV_WIDTH-1];
  assign w_b_neg     = bus.signed_div & bus.opdata2[DIV_WIDTH-1];
  assign w_a_mag     = w_a_neg ? -bus.opdata1 : bus.opdata1;
  assign w_b_mag     = w_b_neg ? -bus.opdata2 : bus.opdata2;
  assign w_b_zero    = (bus.opdata2 == '0);
  assign w_dz_result = {r_dividend, {DIV_WIDTH{1'b1}}};

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem),
    .o_quo     (w_quo)
  );

  // Fix-up operates on the final step's outputs so the result lands on DONE entry.
  assign w_q_fix = r_neg_q ? -w_quo : w_quo;
  assign w_r_fix = r_neg_r ? -w_rem[DIV_WIDTH-1:0] : w_rem[DIV_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (bus.annul) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_cnt      <= '0;
              r_rem      <= '0;
              r_quo      <= w_a_mag;
              r_divisor  <= w_b_mag;
              r_dividend <= bus.opdata1;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_dz       <= w_b_zero;
`ifdef DIV_ZERO_FAST_EN
              r_state    <= w_b_zero ? S_DIVZERO : S_BUSY;
`else
              r_state    <= S_BUSY;
`endif
            end
          end
`ifdef DIV_ZERO_FAST_EN
          S_DIVZERO: begin
            r_result <= w_dz_result;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
`endif
          S_BUSY: begin
            r_rem <= w_rem;
            r_quo <= w_quo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ITER_LAST) begin
              r_result <= r_dz ? w_dz_result : {w_r_fix, w_q_fix};
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.result = r_result;
  assign bus.ready  = r_ready;
  assign bus.stall  = ((r_state == S_IDLE) & bus.start & ~bus.annul)
                    | (r_state == S_BUSY)
                    | (r_state == S_DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - table-driven scoreboard bench for div_unit
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam int LZ = 2;
`else
  localparam int LZ = 33;
`endif
  localparam int LB = 33;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t        vecs[11];
  logic [63:0] sb_q[$];
  logic [63:0] last_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending op");
      end else begin
        check("result", bus.result, sb_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input string name);
    int m;
    bit seen;
    @(negedge clk);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    sb_q.push_back(exp);
    last_exp = exp;
    #1 check({name, " stall_at_start"}, 64'(bus.stall), 64'd1);
    seen = 0;
    for (m = 1; m <= 40; m++) begin
      @(negedge clk);
      if (m == 1) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~sd;
      end
      if (bus.ready === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus.stall !== 1'b1) check({name, " stall_busy"}, 64'(bus.stall), 64'd1);
    end
    check({name, " latency"}, 64'(m), 64'(lat));
    if (seen) check({name, " stall_done"}, 64'(bus.stall), 64'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0]        ra, rb;
    logic signed [31:0] sa, sb2, sq, sr;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, LB, "divu_100_7"};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, LB, "div_m7_2"};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, LB, "div_ovf"};
    vecs[3]  = '{1'b0, 32'h12345678,   32'h0,          64'h12345678_FFFFFFFF, LZ, "divu_zero"};
    vecs[4]  = '{1'b1, 32'h80000001,   32'h0,          64'h80000001_FFFFFFFF, LZ, "div_zero"};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'h1,          64'h00000000_FFFFFFFF, LB, "divu_max_1"};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, LB, "divu_max_max"};
    vecs[7]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, LB, "div_7_m2"};
    vecs[8]  = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, LB, "divu_small"};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, LB, "div_m7_m2"};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, LB, "divu_big"};

    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset result", bus.result, 64'h0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 0) rb = 32'd3;
      do_op(1'b0, ra, rb, {ra % rb, ra / rb}, LB, "divu_rand");
      sa  = $signed($urandom);
      sb2 = $signed($urandom >> $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) sb2 = -sb2;
      if (sb2 == 0) sb2 = -32'sd5;
      sq = sa / sb2;
      sr = sa % sb2;
      do_op(1'b1, sa, sb2, {sr, sq}, LB, "div_rand");
    end

    // Annul at N+10 mid-BUSY: back to IDLE, no ready, result untouched.
    @(negedge clk);
    bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.start = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul stall", 64'(bus.stall), 64'd0);
    check("annul ready", 64'(bus.ready), 64'd0);
    bus.annul = 1'b0; bus.start = 1'b0;
    #1 check("annul idle_stall", 64'(bus.stall), 64'd0);
    repeat (40) @(negedge clk);
    check("annul result_held", bus.result, last_exp);

    // Reset at N+5 mid-BUSY: outputs clear, then a fresh op completes.
    @(negedge clk);
    bus.signed_div = 1'b0; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("rst result", bus.result, 64'h0);
    check("rst ready", 64'(bus.ready), 64'd0);
    check("rst stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;
    do_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, LB, "divu_after_rst");

    repeat (5) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
